// File: rtl/drive_cmd_sequencer.sv
// Drive command sequencer: auto/manual source select, minimum dwell, braking on side reversal, e-stop.
// Optional source watchdog (TIMEOUT state, wdog_tripped) is built when DRIVE_SEQ_WDOG_EN is defined.
module drive_cmd_sequencer #(
   parameter int MIN_DWELL    = 2500000,
   parameter int BRAKE_CYCLES = 5000000,
   parameter int WDOG_CYCLES  = 25000000,
   parameter int CNT_W = $clog2((MIN_DWELL > BRAKE_CYCLES)
                                ? ((MIN_DWELL > WDOG_CYCLES) ? MIN_DWELL : WDOG_CYCLES)
                                : ((BRAKE_CYCLES > WDOG_CYCLES) ? BRAKE_CYCLES : WDOG_CYCLES)) + 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] auto_cmd,
   input  logic       auto_valid,
   input  logic [2:0] manual_cmd,
   input  logic       manual_valid,
   input  logic       manual_mode,
   input  logic       estop,
   output logic [2:0] cmd_out,
   output logic       cmd_strobe,
   output logic       brake_active,
   output logic       wdog_tripped
);
   // state   | meaning
   // HOLD    | cmd_out stable, dwell timer running, requests evaluated
   // BRAKE   | forced Stop after a left/right reversal, pending command released at the end
   // TIMEOUT | selected source went silent, Stop forced until its next valid
   typedef enum logic [1:0] {HOLD = 2'd0, BRAKE = 2'd1, TIMEOUT = 2'd2} state_t;

   localparam logic [2:0]       STOP      = 3'd0;
   localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MIN_DWELL);
   localparam logic [CNT_W-1:0] BRK_LAST  = CNT_W'(BRAKE_CYCLES - 1);

   state_t           state;
   logic [2:0]       pending;
   logic [CNT_W-1:0] dwell_cnt;
   logic [CNT_W-1:0] brk_cnt;
   logic [2:0]       sel_cmd;
   logic [2:0]       req;
   logic             sel_valid;
   logic             reversal;

   function automatic logic is_left(input logic [2:0] c);
      return (c == 3'd1) || (c == 3'd2);
   endfunction

   function automatic logic is_right(input logic [2:0] c);
      return (c == 3'd4) || (c == 3'd5);
   endfunction

   // Codes 6 and 7 are folded into Stop before any decision is made.
   always_comb begin
      sel_cmd   = manual_mode ? manual_cmd : auto_cmd;
      sel_valid = manual_mode ? manual_valid : auto_valid;
      req       = (sel_cmd > 3'd5) ? STOP : sel_cmd;
      reversal  = (is_left(cmd_out) && is_right(req)) || (is_right(cmd_out) && is_left(req));
   end

`ifdef DRIVE_SEQ_WDOG_EN
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WDOG_CYCLES - 1);
   logic [CNT_W-1:0] wd_cnt;
   logic             mode_q;
   logic             wdog_q;
   logic             mode_change;

   assign mode_change  = manual_mode ^ mode_q;
   assign wdog_tripped = wdog_q;
`else
   assign wdog_tripped = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= HOLD;
         cmd_out      <= STOP;
         cmd_strobe   <= 1'b0;
         brake_active <= 1'b0;
         pending      <= STOP;
         dwell_cnt    <= '0;
         brk_cnt      <= '0;
`ifdef DRIVE_SEQ_WDOG_EN
         wd_cnt       <= '0;
         wdog_q       <= 1'b0;
`endif
      end else begin
         cmd_strobe <= 1'b0;
         if (estop) begin
            state        <= HOLD;
            cmd_out      <= STOP;
            cmd_strobe   <= (cmd_out != STOP);
            brake_active <= 1'b0;
            pending      <= STOP;
            dwell_cnt    <= '0;
            brk_cnt      <= '0;
`ifdef DRIVE_SEQ_WDOG_EN
            wd_cnt       <= '0;
            wdog_q       <= 1'b0;
`endif
         end
`ifdef DRIVE_SEQ_WDOG_EN
         else if (state != TIMEOUT && wd_cnt == WD_LAST) begin
            state        <= TIMEOUT;
            cmd_out      <= STOP;
            cmd_strobe   <= (cmd_out != STOP);
            brake_active <= 1'b0;
            pending      <= STOP;
            wd_cnt       <= '0;
            wdog_q       <= 1'b1;
         end
`endif
         else begin
`ifdef DRIVE_SEQ_WDOG_EN
            if (state == TIMEOUT || sel_valid || mode_change)
               wd_cnt <= '0;
            else if (wd_cnt != WD_LAST)
               wd_cnt <= wd_cnt + CNT_W'(1);
`endif
            case (state)
               HOLD: begin
                  if (dwell_cnt != DWELL_MAX)
                     dwell_cnt <= dwell_cnt + CNT_W'(1);
                  if (sel_valid && req != cmd_out) begin
                     if (req == STOP) begin
                        cmd_out    <= STOP;
                        cmd_strobe <= 1'b1;
                        dwell_cnt  <= '0;
                     end else if (dwell_cnt >= DWELL_MAX) begin
                        cmd_strobe <= 1'b1;
                        if (reversal) begin
                           cmd_out      <= STOP;
                           pending      <= req;
                           brk_cnt      <= '0;
                           brake_active <= 1'b1;
                           state        <= BRAKE;
                        end else begin
                           cmd_out   <= req;
                           dwell_cnt <= '0;
                        end
                     end
                  end
               end
               BRAKE: begin
                  if (sel_valid && req == STOP) begin
                     state        <= HOLD;
                     brake_active <= 1'b0;
                     pending      <= STOP;
                     dwell_cnt    <= '0;
                  end else if (brk_cnt == BRK_LAST) begin
                     // A request arriving on the final brake cycle is the newest pending value.
                     state        <= HOLD;
                     brake_active <= 1'b0;
                     cmd_out      <= sel_valid ? req : pending;
                     cmd_strobe   <= 1'b1;
                     pending      <= STOP;
                     dwell_cnt    <= '0;
                  end else begin
                     if (sel_valid)
                        pending <= req;
                     brk_cnt <= brk_cnt + CNT_W'(1);
                  end
               end
               TIMEOUT: begin
                  if (sel_valid) begin
                     state      <= HOLD;
                     cmd_out    <= req;
                     cmd_strobe <= (req != STOP);
                     dwell_cnt  <= '0;
`ifdef DRIVE_SEQ_WDOG_EN
                     wdog_q     <= 1'b0;
`endif
                  end
               end
               default: state <= HOLD;
            endcase
         end
      end
   end

`ifdef DRIVE_SEQ_WDOG_EN
   always_ff @(posedge clk) begin
      mode_q <= manual_mode;
   end
`endif

endmodule

// File: tb/tb_drive_cmd_sequencer.sv
// Bench for drive_cmd_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic compared each cycle against a timestamp-based reference model.
module tb_drive_cmd_sequencer;
   localparam int MD = 4;
   localparam int BC = 3;
   localparam int WC = 10;
`ifdef DRIVE_SEQ_WDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] auto_cmd = '0;
   logic       auto_valid = 1'b0;
   logic [2:0] manual_cmd = '0;
   logic       manual_valid = 1'b0;
   logic       manual_mode = 1'b0;
   logic       estop = 1'b0;
   logic [2:0] cmd_out;
   logic       cmd_strobe;
   logic       brake_active;
   logic       wdog_tripped;

   always #5 clk = ~clk;

   drive_cmd_sequencer #(.MIN_DWELL(MD), .BRAKE_CYCLES(BC), .WDOG_CYCLES(WC)) dut (
      .clk(clk), .reset(reset),
      .auto_cmd(auto_cmd), .auto_valid(auto_valid),
      .manual_cmd(manual_cmd), .manual_valid(manual_valid),
      .manual_mode(manual_mode), .estop(estop),
      .cmd_out(cmd_out), .cmd_strobe(cmd_strobe),
      .brake_active(brake_active), .wdog_tripped(wdog_tripped)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit cur_mode = 1'b0;

   // Reference model: tracks timestamps of the last command change, brake end and last source activity.
   logic [2:0] m_cmd = '0;
   logic [2:0] m_pend = '0;
   bit m_stb = 0, m_brk = 0, m_trip = 0, prev_mode = 0;
   int t_change = 0, brake_end = 0, last_ref = 0;

   function automatic int side(input logic [2:0] c);
      if (c == 3'd1 || c == 3'd2) return -1;
      if (c == 3'd4 || c == 3'd5) return 1;
      return 0;
   endfunction

   task automatic model_step(input bit r, input logic [2:0] ac, input bit av,
                             input logic [2:0] mc, input bit mv, input bit mm, input bit es);
      logic [2:0] req, nxt;
      bit v, mchg;
      nxt  = m_cmd;
      req  = mm ? mc : ac;
      if (req > 3'd5) req = 3'd0;
      v    = mm ? mv : av;
      mchg = (mm != prev_mode);
      prev_mode = mm;
      if (r) begin
         nxt = 0; m_brk = 0; m_trip = 0; m_pend = 0; t_change = cyc + 1; last_ref = cyc;
      end else if (es) begin
         nxt = 0; m_brk = 0; m_trip = 0; m_pend = 0; t_change = cyc + 1; last_ref = cyc;
      end else if (WD_EN && !m_trip && (cyc - last_ref) == WC) begin
         nxt = 0; m_brk = 0; m_trip = 1; m_pend = 0; last_ref = cyc;
      end else begin
         if (v || mchg || m_trip) last_ref = cyc;
         if (m_trip) begin
            if (v) begin m_trip = 0; nxt = req; t_change = cyc + 1; end
         end else if (m_brk) begin
            if (v && req == 0) begin
               m_brk = 0; m_pend = 0; t_change = cyc + 1;
            end else if (cyc == brake_end) begin
               m_brk = 0; nxt = v ? req : m_pend; m_pend = 0; t_change = cyc + 1;
            end else if (v) m_pend = req;
         end else if (v && req != m_cmd) begin
            if (req == 0) begin
               nxt = 0; t_change = cyc + 1;
            end else if (cyc - t_change >= MD) begin
               if (side(m_cmd) * side(req) == -1) begin
                  nxt = 0; m_brk = 1; m_pend = req; brake_end = cyc + BC;
               end else begin
                  nxt = req; t_change = cyc + 1;
               end
            end
         end
      end
      m_stb = r ? 1'b0 : (nxt != m_cmd);
      m_cmd = nxt;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input bit r, input logic [2:0] ac, input bit av,
                       input logic [2:0] mc, input bit mv, input bit mm, input bit es);
      reset = r; auto_cmd = ac; auto_valid = av;
      manual_cmd = mc; manual_valid = mv; manual_mode = mm; estop = es;
      model_step(r, ac, av, mc, mv, mm, es);
      @(posedge clk); #1;
      cyc++;
      check("model_cmd",  32'(cmd_out),      32'(m_cmd));
      check("model_stb",  32'(cmd_strobe),   32'(m_stb));
      check("model_brk",  32'(brake_active), 32'(m_brk));
      check("model_wdog", 32'(wdog_tripped), 32'(m_trip));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 3'd0, 0, 3'd0, 0, cur_mode, 0);
   endtask

   task automatic expect_out(input string tag, input logic [2:0] c, input bit s, input bit b, input bit w);
      check({tag, "_cmd"},  32'(cmd_out),      32'(c));
      check({tag, "_stb"},  32'(cmd_strobe),   32'(s));
      check({tag, "_brk"},  32'(brake_active), 32'(b));
      check({tag, "_wdog"}, 32'(wdog_tripped), 32'(w));
   endtask

   typedef struct {
      bit         r;
      logic [2:0] ac;
      bit         av;
      logic [2:0] cmd;
      bit         stb, brk, wd;
   } vec_t;

   function automatic vec_t mk(input bit r, input logic [2:0] ac, input bit av,
                               input logic [2:0] cmd, input bit stb, input bit brk, input bit wd);
      vec_t v;
      v.r = r; v.ac = ac; v.av = av; v.cmd = cmd; v.stb = stb; v.brk = brk; v.wd = wd;
      return v;
   endfunction

   vec_t tbl [0:21];

   initial begin
      int es_hold;
      bit rr, ee, av, mv;
      logic [2:0] ac, mc;

      // Dwell and reversal scenarios; rows 1-5 let the post-reset dwell expire.
      tbl[0] = mk(1, 3'd0, 0, 3'd0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) tbl[i] = mk(0, 3'd0, 0, 3'd0, 0, 0, 0);
      tbl[6] = mk(0, 3'd3, 1, 3'd3, 1, 0, 0);
      tbl[7] = mk(0, 3'd0, 0, 3'd3, 0, 0, 0);
      tbl[8] = mk(0, 3'd2, 1, 3'd3, 0, 0, 0);
      for (int i = 9; i <= 11; i++) tbl[i] = mk(0, 3'd0, 0, 3'd3, 0, 0, 0);
      tbl[12] = mk(0, 3'd2, 1, 3'd2, 1, 0, 0);
      for (int i = 13; i <= 16; i++) tbl[i] = mk(0, 3'd0, 0, 3'd2, 0, 0, 0);
      tbl[17] = mk(0, 3'd4, 1, 3'd0, 1, 1, 0);
      tbl[18] = mk(0, 3'd0, 0, 3'd0, 0, 1, 0);
      tbl[19] = mk(0, 3'd0, 0, 3'd0, 0, 1, 0);
      tbl[20] = mk(0, 3'd0, 0, 3'd4, 1, 0, 0);
      tbl[21] = mk(0, 3'd0, 0, 3'd4, 0, 0, 0);

      for (int i = 0; i <= 21; i++) begin
         step(tbl[i].r, tbl[i].ac, tbl[i].av, 3'd0, 0, 0, 0);
         expect_out($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].stb, tbl[i].brk, tbl[i].wd);
      end

      // Stop bypasses dwell right after a new command.
      idle(3);
      step(0, 3'd5, 1, 3'd0, 0, 0, 0);
      expect_out("stop_a", 3'd5, 1, 0, 0);
      step(0, 3'd0, 1, 3'd0, 0, 0, 0);
      expect_out("stop_b", 3'd0, 1, 0, 0);

      // E-stop on the second brake cycle drops the pending Right.
      idle(4);
      step(0, 3'd2, 1, 3'd0, 0, 0, 0);
      expect_out("es_left", 3'd2, 1, 0, 0);
      idle(4);
      step(0, 3'd4, 1, 3'd0, 0, 0, 0);
      expect_out("es_brk0", 3'd0, 1, 1, 0);
      idle(1);
      step(0, 3'd0, 0, 3'd0, 0, 0, 1);
      expect_out("es_hit", 3'd0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         idle(1);
         expect_out($sformatf("es_quiet%0d", k), 3'd0, 0, 0, 0);
      end
      step(0, 3'd3, 1, 3'd0, 0, 0, 0);
      expect_out("es_resume", 3'd3, 1, 0, 0);

      // Watchdog: ten silent cycles, then manual source recovers.
      idle(9);
      expect_out("wd_pre", 3'd3, 0, 0, 0);
      idle(1);
      expect_out("wd_trip", WD_EN ? 3'd0 : 3'd3, WD_EN, 0, WD_EN);
      cur_mode = 1'b1;
      step(0, 3'd0, 0, 3'd1, 1, cur_mode, 0);
      expect_out("wd_manual", 3'd1, 1, 0, 0);
      cur_mode = 1'b0;

      // Reset during brake with Right pending: Right must never appear.
      idle(4);
      step(0, 3'd4, 1, 3'd0, 0, 0, 0);
      expect_out("rst_brk", 3'd0, 1, 1, 0);
      step(1, 3'd0, 0, 3'd0, 0, 0, 0);
      expect_out("rst_hit", 3'd0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         idle(1);
         expect_out($sformatf("rst_quiet%0d", k), 3'd0, 0, 0, 0);
      end

      // Randomized traffic with held e-stop pulses and periodic silent stretches.
      es_hold = 0;
      for (int i = 0; i < 3000; i++) begin
         rr = ($urandom_range(0, 299) == 0);
         if (es_hold == 0 && $urandom_range(0, 59) == 0) es_hold = $urandom_range(1, 4);
         ee = (es_hold > 0);
         if (es_hold > 0) es_hold--;
         if ($urandom_range(0, 39) == 0) cur_mode = ~cur_mode;
         av = ((i % 200) < 170) && ($urandom_range(0, 3) == 0);
         mv = ((i % 200) < 170) && ($urandom_range(0, 3) == 0);
         ac = 3'($urandom_range(0, 7));
         mc = 3'($urandom_range(0, 7));
         step(rr, ac, av, mc, mv, cur_mode, ee);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
